// File: rtl/issue_scheduler.sv
// Issue scheduler for the 2-stage jericalla datapath: a small instruction FIFO that
// inserts NOP bubbles while a source register waits on an in-flight write.
module issue_scheduler #(
   parameter int          DEPTH      = 4,
   parameter logic [3:0]  NOP_OPCODE = 4'hF,
   parameter logic [15:0] WB_MASK    = 16'h7FFF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [18:0]              in_instr,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [18:0]              instruction,
   output logic                     issue_valid,
   output logic                     stall,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [15:0]              stall_count
);

   // state | meaning
   // EMPTY | FIFO empty (or just flushed): bubble on the datapath, stall = 0
   // ISSUE | head popped onto the datapath, issue_valid = 1
   // STALL | head waits on an in-flight write: bubble, stall = 1

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [18:0] NOP_INSTR = {NOP_OPCODE, 15'b0};

   // one bit per output flag so issue_valid/stall come straight from flops
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ISSUE = 2'b01,
      STALL = 2'b10
   } state_t;

   state_t state, state_nxt;

   logic [18:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;
   logic [18:0]   head;
   logic [4:0]    head_src1, head_src2;

   logic [4:0]    sb0_dest, sb1_dest;
   logic          sb0_we, sb1_we;
   logic          hazard;

   logic [18:0]   instr_nxt;
   logic          we_nxt;

   assign in_ready   = (count < CW'(DEPTH)) && !flush;
   assign push       = in_valid && in_ready;
   assign fifo_count = count;

   assign head      = mem[rd_ptr];
   assign head_src1 = head[9:5];
   assign head_src2 = head[4:0];

   // slot0 is the instruction now on the datapath, slot1 the one before it
   assign hazard = (sb0_we && (sb0_dest == head_src1 || sb0_dest == head_src2)) ||
                   (sb1_we && (sb1_dest == head_src1 || sb1_dest == head_src2));

   assign issue_valid = (state == ISSUE);
   assign stall       = (state == STALL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= EMPTY;
         instruction <= NOP_INSTR;
      end else begin
         state       <= state_nxt;
         instruction <= instr_nxt;
      end
   end

   always_comb begin
      state_nxt = EMPTY;
      pop       = 1'b0;
      instr_nxt = NOP_INSTR;
      if (flush) begin
         state_nxt = EMPTY;
      end else if (count == '0) begin
         state_nxt = EMPTY;
      end else if (hazard) begin
         state_nxt = STALL;
      end else begin
         state_nxt = ISSUE;
         pop       = 1'b1;
         instr_nxt = head;
      end
      we_nxt = pop && WB_MASK[head[18:15]];
   end

   // storage needs no reset: entries are only read while count is non-zero
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_instr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   // keeps shifting through a flush so writes already issued are still honoured
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb0_dest <= '0;
         sb0_we   <= 1'b0;
         sb1_dest <= '0;
         sb1_we   <= 1'b0;
      end else begin
         sb0_dest <= instr_nxt[14:10];
         sb0_we   <= we_nxt;
         sb1_dest <= sb0_dest;
         sb1_we   <= sb0_we;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (state_nxt == STALL && stall_count != 16'hFFFF) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Instruction issue controller placed in front of the 2-stage jericalla datapath: control/register-read, then buffer1→ALU/demux, then buffer2→RAM/register write-back.
- Accepts 19-bit instructions from a producer over a valid/ready handshake and queues them in a small FIFO.
- Presents one instruction per cycle to the datapath `instruction` input.
- Inserts NOP bubbles when a source register depends on a write still in flight, because the datapath has no forwarding.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- NOP_OPCODE, 4'hF, opcode driven on bubbles; the NOP instruction is {NOP_OPCODE, 15'b0}.
- WB_MASK, 16'h7FFF, bit i=1 means opcode i writes the register bank; a bubble never writes, regardless of mask.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  producer has an instruction
- in_instr  input  19  [18:15] opcode, [14:10] dest, [9:5] src1, [4:0] src2
- in_ready  output  1  FIFO can accept; combinational, = (count < DEPTH) && !flush
- flush  input  1  synchronous: empty the FIFO and issue a NOP next cycle
- instruction  output  19  registered instruction driven to the datapath
- issue_valid  output  1  registered; 1 = `instruction` is a real instruction, 0 = bubble
- stall  output  1  registered; 1 = the current bubble is due to a hazard (FIFO non-empty)
- fifo_count  output  $clog2(DEPTH)+1  current occupancy
- stall_count  output  16  saturating count of hazard bubbles

Behaviour:
- Reset (async, any time, including mid-stall):
  - instruction = {NOP_OPCODE, 15'b0}; issue_valid = 0; stall = 0.
  - FIFO emptied; fifo_count = 0; stall_count = 0.
  - Scoreboard cleared; state = EMPTY.
- Write-back timing:
  - An instruction presented at cycle t reads the register bank during t.
  - Its result becomes readable at t+3.
  - A source therefore conflicts with the destination of any writing instruction presented at t or t-1 (the two scoreboard slots).
- Scoreboard:
  - slot0 = {dest, we} of the instruction currently on `instruction`.
  - slot1 = previous slot0.
  - Shifts every cycle; a bubble shifts in we = 0.
- Hazard rule for the FIFO head (evaluated each cycle for the next output):
  - hazard = (slotK.we && slotK.dest == head.src1) || (slotK.we && slotK.dest == head.src2), for K = 0 or 1.
  - Both sources are always checked, for every opcode.
  - Register 0 is not special-cased.
- FSM states: EMPTY, ISSUE, STALL.
  - EMPTY: FIFO empty. Emit a bubble with stall = 0. Go to ISSUE when count becomes non-zero.
  - ISSUE: head present and no hazard. Pop head onto `instruction`, issue_valid = 1. Stay in ISSUE if more entries remain; go to EMPTY if the FIFO empties; go to STALL if the next head has a hazard.
  - STALL: head has a hazard. Emit a bubble, stall = 1, stall_count += 1 (saturates at 16'hFFFF). Go to ISSUE once the hazard clears (at most 2 cycles).
- FIFO:
  - Push when in_valid && in_ready; pop on issue.
  - Simultaneous push and pop with count == DEPTH is not allowed, since in_ready = 0 when full.
  - A push into an empty FIFO is issuable no earlier than the next cycle (1-cycle minimum latency, in_instr to `instruction`).
  - Pointers wrap modulo DEPTH.
- flush:
  - Has priority over push and pop. Count → 0; next output is a bubble; state → EMPTY.
  - The scoreboard still shifts, so in-flight writes are honoured.
- Bubbles:
  - Opcode is NOP_OPCODE; the other bits are 0.
  - The scheduler never drives the datapath write-enable directly; the control unit decodes NOP_OPCODE as no-write.

Test Plan:
- Independent stream: push 3 instructions with disjoint registers, e.g. 19'h0_0C41 and others → issued on 3 consecutive cycles; issue_valid = 1 each; stall_count = 0.
- Back-to-back RAW: opcode 0 dest=3, then src1=3 → 2 bubbles with stall = 1, the dependent instruction issues on the 3rd cycle after the producer; stall_count = 2.
- Distance-2 RAW: dest=5, an unrelated instruction, then src2=5 → exactly 1 bubble; stall_count = 1.
- Non-writing producer: producer opcode has its WB_MASK bit cleared and dest=7, followed by src1=7 → no stall.
- Backpressure: hold issue in STALL with 4 pushes outstanding → fifo_count = 4, in_ready = 0; a 5th in_valid is not accepted; the item is accepted after the next pop.
- Flush/reset: assert flush with count = 3 → next cycle count = 0, bubble, state EMPTY. Assert rst mid-STALL → all outputs at reset values immediately, without waiting for a clock edge.
